// File: rtl/sipo_deserializer_if.sv
// Bundle of serial-input, parallel-output and error signals of the SIPO receiver.
// The receiver connects through the slave modport; the stream source and sink use the master modport.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             start;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             err_clr;

  modport slave (
    input  sin, sin_valid, start, pout_ready, err_clr,
    output pout, pout_valid, busy, overrun, frame_err
  );

  modport master (
    output sin, sin_valid, start, pout_ready, err_clr,
    input  pout, pout_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Framed, MSB-first serial-to-parallel receiver with a one-word holding register,
// a valid/ready output handshake and sticky overrun/framing error flags.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  sipo_deserializer_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] pout_q;
  logic             pout_valid_q;
  logic             busy_q;
  logic             overrun_q;
  logic             frame_err_q;

  logic             first_bit;
  logic             next_bit;
  logic             complete;
  logic             consume;
  logic [WIDTH-1:0] word;

  assign first_bit = bus.sin_valid & bus.start;
  assign next_bit  = bus.sin_valid & ~bus.start;
  assign complete  = (state == SHIFT) & next_bit & (bit_cnt == LAST);
  assign consume   = pout_valid_q & bus.pout_ready;
  assign word      = {shreg[WIDTH-2:0], bus.sin};

  // A start seen mid-word resynchronises onto the new word and flags the framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (first_bit) begin
            shreg   <= WIDTH'(bus.sin);
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (first_bit) begin
            shreg   <= WIDTH'(bus.sin);
            bit_cnt <= CNT_W'(1);
          end else if (next_bit) begin
            shreg <= word;
            if (complete) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      // A completed word only replaces pout when the slot is empty or being drained this edge.
      if (complete) begin
        if (!pout_valid_q || consume) begin
          pout_q       <= word;
          pout_valid_q <= 1'b1;
        end
      end else if (consume) begin
        pout_valid_q <= 1'b0;
      end

      if (bus.err_clr) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (complete && pout_valid_q && !consume) begin
        overrun_q <= 1'b1;
      end
      if (state == SHIFT && first_bit) begin
        frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed vector table, hand-written stall and
// reset sequences, then randomized traffic compared against a bit-queue reference model.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic         sv;
    logic         sin;
    logic         rdy;
    logic         clr;
    logic [W-1:0] pout;
    logic         pv;
    logic         busy;
    logic         ovr;
    logic         ferr;
  } vec_t;

  vec_t tbl [38];

  // Reference model state: bits of the word being assembled plus the visible outputs.
  bit           m_in_word;
  bit           m_bits [$];
  logic [W-1:0] m_pout;
  bit           m_pv;
  bit           m_ovr;
  bit           m_ferr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sv, input logic s,
                               input logic rdy, input logic clr);
    bus.start      = st;
    bus.sin_valid  = sv;
    bus.sin        = s;
    bus.pout_ready = rdy;
    bus.err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [W-1:0] p, input logic pv,
                          input logic b, input logic o, input logic f);
    checkOutput({tag, ".pout"}, 32'(bus.pout), 32'(p));
    checkOutput({tag, ".pout_valid"}, 32'(bus.pout_valid), 32'(pv));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(b));
    checkOutput({tag, ".overrun"}, 32'(bus.overrun), 32'(o));
    checkOutput({tag, ".frame_err"}, 32'(bus.frame_err), 32'(f));
  endtask

  task automatic modelReset();
    m_in_word = 0;
    m_bits.delete();
    m_pout = '0;
    m_pv   = 0;
    m_ovr  = 0;
    m_ferr = 0;
  endtask

  // Advance the model by one edge from the rules: words are framed by start, completed at W bits.
  task automatic modelStep(input bit st, input bit sv, input bit s, input bit rdy, input bit clr);
    bit           consume;
    bit           done;
    bit           ovr_set;
    bit           ferr_set;
    logic [W-1:0] w;
    consume  = m_pv && rdy;
    done     = 0;
    ovr_set  = 0;
    ferr_set = 0;
    w        = '0;
    if (sv) begin
      if (st) begin
        if (m_in_word) ferr_set = 1;
        m_bits.delete();
        m_bits.push_back(s);
        m_in_word = 1;
      end else if (m_in_word) begin
        m_bits.push_back(s);
        if (m_bits.size() == W) begin
          foreach (m_bits[k]) w = {w[W-2:0], m_bits[k]};
          done = 1;
          m_in_word = 0;
          m_bits.delete();
        end
      end
    end
    if (done) begin
      if (!m_pv || consume) begin
        m_pout = w;
        m_pv   = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (consume) begin
      m_pv = 0;
    end
    if (clr) begin
      m_ovr  = 0;
      m_ferr = 0;
    end
    if (ovr_set) m_ovr = 1;
    if (ferr_set) m_ferr = 1;
  endtask

  initial begin
    logic [W-1:0] stall_word;
    checks   = 0;
    failures = 0;

    //               st sv sin rdy clr  pout     pv busy ovr ferr
    tbl[0]  = '{1, 1, 1, 1, 0, 4'b0000, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 4'b0000, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 0, 4'b0000, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 4'b1011, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 4'b1011, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 4'b1011, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 0, 4'b1011, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 4'b1011, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 4'b1100, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 4'b1100, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 4'b1100, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 0, 4'b1100, 1, 1, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 0, 4'b1100, 1, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 4'b1100, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 1, 1, 4'b1100, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 4'b1100, 0, 1, 0, 0};
    tbl[16] = '{0, 1, 1, 0, 0, 4'b1100, 0, 1, 0, 0};
    tbl[17] = '{0, 1, 0, 0, 0, 4'b1100, 0, 1, 0, 0};
    tbl[18] = '{0, 1, 1, 0, 0, 4'b0101, 1, 0, 0, 0};
    tbl[19] = '{1, 1, 1, 0, 0, 4'b0101, 1, 1, 0, 0};
    tbl[20] = '{0, 1, 1, 0, 0, 4'b0101, 1, 1, 0, 0};
    tbl[21] = '{0, 1, 1, 0, 0, 4'b0101, 1, 1, 0, 0};
    tbl[22] = '{0, 1, 0, 1, 0, 4'b1110, 1, 0, 0, 0};
    tbl[23] = '{0, 0, 0, 1, 0, 4'b1110, 0, 0, 0, 0};
    tbl[24] = '{1, 1, 1, 1, 0, 4'b1110, 0, 1, 0, 0};
    tbl[25] = '{0, 1, 0, 1, 0, 4'b1110, 0, 1, 0, 0};
    tbl[26] = '{1, 1, 1, 1, 0, 4'b1110, 0, 1, 0, 1};
    tbl[27] = '{0, 1, 1, 1, 0, 4'b1110, 0, 1, 0, 1};
    tbl[28] = '{0, 1, 1, 1, 0, 4'b1110, 0, 1, 0, 1};
    tbl[29] = '{0, 1, 1, 1, 0, 4'b1111, 1, 0, 0, 1};
    tbl[30] = '{0, 1, 1, 1, 0, 4'b1111, 0, 0, 0, 1};
    tbl[31] = '{0, 0, 0, 1, 1, 4'b1111, 0, 0, 0, 0};
    tbl[32] = '{1, 1, 0, 1, 0, 4'b1111, 0, 1, 0, 0};
    tbl[33] = '{1, 1, 0, 1, 1, 4'b1111, 0, 1, 0, 1};
    tbl[34] = '{0, 1, 0, 1, 1, 4'b1111, 0, 1, 0, 0};
    tbl[35] = '{0, 1, 1, 1, 0, 4'b1111, 0, 1, 0, 0};
    tbl[36] = '{0, 1, 0, 1, 0, 4'b0010, 1, 0, 0, 0};
    tbl[37] = '{0, 0, 0, 1, 0, 4'b0010, 0, 0, 0, 0};

    bus.start      = 1'b0;
    bus.sin_valid  = 1'b0;
    bus.sin        = 1'b0;
    bus.pout_ready = 1'b0;
    bus.err_clr    = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 4'b0000, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 38; i++) begin
      applyStimulus(tbl[i].start, tbl[i].sv, tbl[i].sin, tbl[i].rdy, tbl[i].clr);
      checkAll($sformatf("vec%0d", i), tbl[i].pout, tbl[i].pv, tbl[i].busy, tbl[i].ovr,
               tbl[i].ferr);
    end

    // Word 1011 with two idle cycles after every bit: busy must hold through the gaps.
    stall_word = 4'b1011;
    for (int b = W - 1; b >= 0; b--) begin
      applyStimulus(b == W - 1, 1'b1, stall_word[b], 1'b1, 1'b0);
      if (b != 0) begin
        checkOutput($sformatf("stall.busy_bit%0d", b), 32'(bus.busy), 32'd1);
        for (int g = 0; g < 2; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
          checkOutput($sformatf("stall.busy_gap%0d_%0d", b, g), 32'(bus.busy), 32'd1);
        end
      end
    end
    checkAll("stall.done", 4'b1011, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stall.drain", 32'(bus.pout_valid), 32'd0);

    // Asynchronous reset between edges after two bits of a word.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("areset.pre_busy", 32'(bus.busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    checkAll("areset.immediate", 4'b0000, 0, 0, 0, 0);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("areset.no_start_ignored", 32'(bus.busy), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("areset.word1001", 4'b1001, 1, 0, 0, 0);

    // Randomized traffic against the reference model.
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    modelReset();
    for (int c = 0; c < 2000; c++) begin
      bit st, sv, s, rdy, clr;
      sv  = ($urandom_range(9, 0) < 7);
      st  = ($urandom_range(7, 0) == 0);
      s   = 1'($urandom_range(1, 0));
      rdy = 1'($urandom_range(1, 0));
      clr = ($urandom_range(15, 0) == 0);
      applyStimulus(st, sv, s, rdy, clr);
      modelStep(st, sv, s, rdy, clr);
      checkAll($sformatf("rand%0d", c), m_pout, m_pv, m_in_word, m_ovr, m_ferr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
